// File: rtl/tone_sequencer_if.sv
// Control, note-ROM and audio-sample signals shared by the tone sequencer and its host.
interface tone_sequencer_if #(
  parameter int ROM_DEPTH = 32
);
  localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

  logic          start;
  logic          stop;
  logic [3:0]    volume;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          audio_out_allowed;
  logic          write_audio_out;
  logic [31:0]   sample_out;
  logic          busy;
  logic          done;

  modport master (
    output start, stop, volume, rom_data, audio_out_allowed,
    input  rom_addr, write_audio_out, sample_out, busy, done
  );

  modport slave (
    input  start, stop, volume, rom_data, audio_out_allowed,
    output rom_addr, write_audio_out, sample_out, busy, done
  );
endinterface

// File: rtl/tone_sequencer.sv
// Plays a song from a note ROM as a square wave: pitch sets the half-period,
// duration counts ticks, volume scales the sample amplitude.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | rom_addr presented, ROM read in flight
// LOAD  | note entry decoded; duration 0 ends the song
// PLAY  | tone/tick counters running, samples generated
// DONE  | one-cycle done pulse
module tone_sequencer #(
  parameter int TICK_DIV  = 5000000,
  parameter int HP_STEP   = 12000,
  parameter int AMP_STEP  = 1000000,
  parameter int ROM_DEPTH = 32
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  tone_sequencer_if.slave  bus
);
  localparam int AW     = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam int TICK_W = $clog2(TICK_DIV + 1);
  localparam int TONE_W = $clog2(15 * HP_STEP + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic              rst_meta_q, rst_sync_q;
  logic [2:0]        state_q, state_d;
  logic [AW-1:0]     rom_addr_q, rom_addr_d;
  logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]        dur_cnt_q, dur_cnt_d;
  logic [3:0]        pitch_q, pitch_d;
  logic              sign_q, sign_d;
  logic [31:0]       sample_q, sample_d;
  logic [TONE_W-1:0] tone_top;
  logic [31:0]       amp;
  logic              tone_wrap, tick_wrap;

  // Assertion is immediate; release is delayed two edges so no state moves on a metastable reset.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign tone_top  = TONE_W'(32'(pitch_q) * 32'(HP_STEP) - 32'd1);
  assign tone_wrap = (tone_cnt_q == tone_top);
  assign tick_wrap = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign amp       = 32'(bus.volume) * 32'(AMP_STEP);

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    tone_cnt_d = tone_cnt_q;
    tick_cnt_d = tick_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    pitch_d    = pitch_q;
    sign_d     = sign_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          rom_addr_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (bus.rom_data[3:0] == 4'd0) begin
          state_d = S_DONE;
        end else begin
          pitch_d    = bus.rom_data[7:4];
          dur_cnt_d  = bus.rom_data[3:0];
          tick_cnt_d = '0;
          tone_cnt_d = '0;
          sign_d     = 1'b0;
          state_d    = S_PLAY;
        end
      end
      S_PLAY: begin
        if (pitch_q != 4'd0) begin
          if (tone_wrap) begin
            tone_cnt_d = '0;
            sign_d     = ~sign_q;
          end else begin
            tone_cnt_d = tone_cnt_q + TONE_W'(1);
          end
        end
        if (tick_wrap) begin
          tick_cnt_d = '0;
          dur_cnt_d  = dur_cnt_q - 4'd1;
          if (dur_cnt_q == 4'd1) begin
            if (rom_addr_q == AW'(ROM_DEPTH - 1)) begin
              rom_addr_d = '0;
              state_d    = S_DONE;
            end else begin
              rom_addr_d = rom_addr_q + AW'(1);
              state_d    = S_FETCH;
            end
          end
        end else begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Stop overrides everything; in IDLE it already blocks start above.
    if (bus.stop && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      rom_addr_d = '0;
    end

    // Built from next-state values so the registered sample lines up with the PLAY cycle it belongs to.
    if (state_d == S_PLAY && pitch_d != 4'd0 && bus.volume != 4'd0) begin
      sample_d = sign_d ? (32'd0 - amp) : amp;
    end else begin
      sample_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      tone_cnt_q <= '0;
      tick_cnt_q <= '0;
      dur_cnt_q  <= '0;
      pitch_q    <= '0;
      sign_q     <= 1'b0;
      sample_q   <= '0;
    end else if (rst_sync_q) begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      tone_cnt_q <= tone_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      pitch_q    <= pitch_d;
      sign_q     <= sign_d;
      sample_q   <= sample_d;
    end
  end

  assign bus.rom_addr        = rom_addr_q;
  assign bus.sample_out      = sample_q;
  assign bus.write_audio_out = bus.audio_out_allowed;
  assign bus.busy            = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_PLAY);
  assign bus.done            = (state_q == S_DONE);
endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with a small clocked note-ROM model.
module tb_tone_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  logic [7:0]  rom_mem [32];
  logic [31:0] POS4 = 32'd4000000;
  logic [31:0] NEG4 = 32'd0 - 32'd4000000;
  logic [31:0] POS2 = 32'd2000000;

  tone_sequencer_if #(.ROM_DEPTH(32)) bus ();

  tone_sequencer #(
    .TICK_DIV (4),
    .HP_STEP  (2),
    .AMP_STEP (1000000),
    .ROM_DEPTH(32)
  ) dut (
    .CLOCK_50(clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) rom_mem[i] = 8'h00;
    bus.start = 1'b0; bus.stop = 1'b0; bus.volume = 4'd4; bus.audio_out_allowed = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sample_out !== 32'd0 || bus.rom_addr !== 5'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b sample=%0d addr=%0d required 0/0/0/0",
               bus.busy, bus.done, bus.sample_out, bus.rom_addr);
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    bus.audio_out_allowed = 1'b0;
    #1 checks++;
    if (bus.write_audio_out !== 1'b0) begin
      errors++; $display("FAIL wao_low got %b required 0", bus.write_audio_out);
    end
    bus.audio_out_allowed = 1'b1;
    #1 checks++;
    if (bus.write_audio_out !== 1'b1) begin
      errors++; $display("FAIL wao_high got %b required 1", bus.write_audio_out);
    end
  endtask

  task automatic test_basic_note();
    logic [31:0] exp;
    int d0;
    rom_mem[0] = 8'h12; rom_mem[1] = 8'h00;
    d0 = done_cnt;
    pulse_start();
    checks++;
    if (bus.busy !== 1'b1 || bus.rom_addr !== 5'd0) begin
      errors++; $display("FAIL basic_busy busy=%b addr=%0d required 1/0", bus.busy, bus.rom_addr);
    end
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      exp = ((k / 2) % 2 == 0) ? POS4 : NEG4;
      checks++;
      if (bus.sample_out !== exp || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_play%0d sample=%0d busy=%b required %0d/1",
                 k, $signed(bus.sample_out), bus.busy, $signed(exp));
      end
      @(negedge clk);
    end
    checks++;
    if (bus.sample_out !== 32'd0 || bus.busy !== 1'b1 || bus.rom_addr !== 5'd1) begin
      errors++;
      $display("FAIL basic_fetch2 sample=%0d busy=%b addr=%0d required 0/1/1",
               bus.sample_out, bus.busy, bus.rom_addr);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL basic_done done=%b busy=%b required 1/0", bus.done, bus.busy);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL basic_after done=%b busy=%b pulses=%0d required 0/0/1", bus.done, bus.busy, done_cnt - d0);
    end
  endtask

  task automatic test_rest_note();
    int bad;
    rom_mem[0] = 8'h03; rom_mem[1] = 8'h00;
    bus.audio_out_allowed = 1'b0;
    bad = 0;
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      if (bus.sample_out !== 32'd0 || bus.busy !== 1'b1 || bus.write_audio_out !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rest_play bad_cycles=%0d required 0", bad);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++; $display("FAIL rest_done done=%b required 1", bus.done);
    end
    bus.audio_out_allowed = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stop();
    int d0;
    rom_mem[0] = 8'h12; rom_mem[1] = 8'h12; rom_mem[2] = 8'h00;
    d0 = done_cnt;
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.sample_out !== NEG4) begin
      errors++; $display("FAIL stop_pre sample=%0d required %0d", $signed(bus.sample_out), $signed(NEG4));
    end
    bus.stop = 1'b1;
    @(negedge clk) bus.stop = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.sample_out !== 32'd0 || bus.rom_addr !== 5'd0) begin
      errors++;
      $display("FAIL stop_idle busy=%b sample=%0d addr=%0d required 0/0/0", bus.busy, bus.sample_out, bus.rom_addr);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != d0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL stop_nodone pulses=%0d busy=%b required 0/0", done_cnt - d0, bus.busy);
    end
  endtask

  task automatic test_rom_wrap();
    int bad;
    for (int i = 0; i < 32; i++) rom_mem[i] = 8'h11;
    bad = 0;
    pulse_start();
    for (int i = 0; i < 32; i++) begin
      if (bus.rom_addr !== 5'(i) || bus.busy !== 1'b1) bad++;
      repeat (6) @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wrap_addr_seq bad=%0d required 0", bad);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.rom_addr !== 5'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_done done=%b addr=%0d busy=%b required 1/0/0", bus.done, bus.rom_addr, bus.busy);
    end
    @(negedge clk);
    for (int i = 0; i < 32; i++) rom_mem[i] = 8'h00;
  endtask

  task automatic test_async_reset();
    rom_mem[0] = 8'h12; rom_mem[1] = 8'h00;
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 checks++;
    if (bus.sample_out !== 32'd0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL async_rst sample=%0d busy=%b required 0/0", bus.sample_out, bus.busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL rst_sync_early busy=%b required 0", bus.busy);
    end
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL rst_sync_start busy=%b required 1", bus.busy);
    end
    bus.stop = 1'b1;
    @(negedge clk) bus.stop = 1'b0;
  endtask

  task automatic test_start_stop_idle();
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.rom_addr !== 5'd0) begin
      errors++; $display("FAIL start_stop busy=%b addr=%0d required 0/0", bus.busy, bus.rom_addr);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL start_stop_later busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_volume();
    rom_mem[0] = 8'h12; rom_mem[1] = 8'h00;
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.sample_out !== POS4) begin
      errors++; $display("FAIL vol_play0 sample=%0d required %0d", $signed(bus.sample_out), $signed(POS4));
    end
    bus.volume = 4'd0;
    @(negedge clk);
    checks++;
    if (bus.sample_out !== 32'd0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL vol_mute sample=%0d busy=%b required 0/1", $signed(bus.sample_out), bus.busy);
    end
    @(negedge clk);
    bus.volume = 4'd4;
    @(negedge clk);
    checks++;
    if (bus.sample_out !== NEG4) begin
      errors++; $display("FAIL vol_resume sample=%0d required %0d", $signed(bus.sample_out), $signed(NEG4));
    end
    bus.volume = 4'd2;
    @(negedge clk);
    checks++;
    if (bus.sample_out !== POS2) begin
      errors++; $display("FAIL vol_two sample=%0d required %0d", $signed(bus.sample_out), $signed(POS2));
    end
    repeat (6) @(negedge clk);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++; $display("FAIL vol_timing done=%b required 1", bus.done);
    end
    bus.volume = 4'd4;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_note();
    test_rest_note();
    test_stop();
    test_rom_wrap();
    test_async_reset();
    test_start_stop_idle();
    test_volume();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 5000000, is the clocks per duration tick (0.1 s at 50 MHz).
REQ-002 Parameter HP_STEP, default 12000, is the clocks per half-period unit per pitch index.
REQ-003 Parameter AMP_STEP, default 1000000, is the amplitude per volume unit.
REQ-004 Parameter ROM_DEPTH, default 32, is the number of note ROM entries; it is a power of two.
REQ-005 CLOCK_50  in  1  sole clock; all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle request to play the song from entry 0.
REQ-008 stop  in  1  abort playback.
REQ-009 volume  in  4  amplitude multiplier; 0 = mute.
REQ-010 rom_addr  out  log2(ROM_DEPTH)  note ROM address.
REQ-011 rom_data  in  8  note entry, valid 1 cycle after rom_addr: [7:4] pitch (0 = rest), [3:0] duration in ticks (0 = end of song).
REQ-012 audio_out_allowed  in  1  Audio_Controller output FIFO has space.
REQ-013 write_audio_out  out  1  sample write strobe to Audio_Controller.
REQ-014 sample_out  out  32  signed sample for both channels.
REQ-015 busy  out  1  high in FETCH, LOAD and PLAY.
REQ-016 done  out  1  one-cycle pulse at normal song end.

Function
REQ-017 FSM states are IDLE, FETCH, LOAD, PLAY and DONE.
REQ-018 IDLE: start=1 and stop=0 -> rom_addr<=0, FETCH; start while busy is ignored.
REQ-019 FETCH: hold rom_addr for one cycle -> LOAD.
REQ-020 LOAD: if duration==0 -> DONE; else latch pitch, set dur_cnt=duration, tick_cnt=0, tone_cnt=0, sign=positive -> PLAY.
REQ-021 PLAY: tone_cnt counts 0..pitch*HP_STEP-1; on wrap, sign toggles; tone_cnt is unused when pitch==0.
REQ-022 PLAY: tick_cnt counts 0..TICK_DIV-1; on wrap, dur_cnt decrements; when dur_cnt reaches 0 on a wrap: if rom_addr==ROM_DEPTH-1 -> DONE with rom_addr<=0, else rom_addr<=rom_addr+1 and -> FETCH.
REQ-023 A note therefore plays exactly duration*TICK_DIV PLAY cycles, plus 2 cycles of FETCH/LOAD overhead between notes.
REQ-024 DONE: done=1 for one cycle -> IDLE.
REQ-025 stop=1 in FETCH, LOAD, PLAY or DONE -> IDLE on the next edge, with no done pulse and rom_addr<=0.
REQ-026 stop has priority over every other transition, including a simultaneous start in IDLE.
REQ-027 Amplitude = volume*AMP_STEP as an unsigned 32-bit value; volume is sampled every cycle, so changes take effect immediately.
REQ-028 sample_out = +amplitude when sign is positive and -amplitude (two's complement) when negative.
REQ-029 sample_out = 0 outside PLAY, when pitch==0, or when volume==0.
REQ-030 sample_out is registered.
REQ-031 write_audio_out = audio_out_allowed, combinationally, in every state, so the FIFO is kept fed (zeros when idle).
REQ-032 Counters do not stall on audio_out_allowed; timing is clock-based only.

Reset
REQ-033 reset_n=0 immediately forces:
- state=IDLE
- rom_addr, tone_cnt, tick_cnt, dur_cnt and pitch = 0
- sign=positive
- sample_out=0, busy=0, done=0
REQ-034 Release of reset_n is synchronized internally; the first start is honoured 2 cycles after release.

Verification (TICK_DIV=4, HP_STEP=2, AMP_STEP=1000000, volume=4)
REQ-035 ROM {0x12, 0x00}, start pulse -> busy=1 the next cycle; 8 PLAY cycles of sample_out +4000000,+4000000,-4000000,-4000000 repeating; then done pulses once and busy=0.
REQ-036 ROM {0x03, 0x00} -> busy for 12 PLAY cycles with sample_out=0 throughout, then done.
REQ-037 stop asserted in PLAY cycle 3 of note 0x12 -> IDLE next cycle, sample_out=0, rom_addr=0, done never asserted.
REQ-038 All 32 entries = 0x11 -> after entry 31 plays (4 cycles), DONE with rom_addr=0; no read of an entry 32.
REQ-039 reset_n low mid-PLAY, asynchronously between clock edges -> sample_out=0 and busy=0 before the next edge.
REQ-040 start=1 and stop=1 in the same IDLE cycle -> remains IDLE, busy=0; volume=0 during a pitched note -> sample_out=0 while timing continues.
